// File: rtl/truth_table_extractor_pkg.sv
// Shared types and constants for the truth-table extraction harness.
// Holds the FSM state encoding, the combination-count helper and the legal parameter bounds.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tt_state_e;

    localparam int N_INPUTS_MAX      = 6;
    localparam int SETTLE_CYCLES_MIN = 1;

    function automatic int num_combos(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_extractor.sv
// Walks every input combination of an external N-input gate in ascending order, waits a
// programmable settle time per combination and assembles the observed 2^N-bit truth table.
module truth_table_extractor
    import tt_pkg::*;
#(
    parameter int N_INPUTS      = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               abort,
    output logic [N_INPUTS-1:0]                stim,
    input  logic                               dut_out,
    output logic                               busy,
    output logic                               done,
    output logic                               tt_valid,
    output logic [num_combos(N_INPUTS)-1:0]    truth_table
);

    localparam int NUM_COMBOS = num_combos(N_INPUTS);
    localparam int IDX_W      = N_INPUTS + 1;
    localparam int CNT_W      = $clog2(SETTLE_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_COMBOS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    generate
        if (N_INPUTS < 1 || N_INPUTS > N_INPUTS_MAX || SETTLE_CYCLES < SETTLE_CYCLES_MIN) begin : g_bad_params
            $error("truth_table_extractor: N_INPUTS must be 1..6 and SETTLE_CYCLES >= 1");
        end
    endgenerate

    tt_state_e               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N_INPUTS-1:0]     stim_q, stim_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    tt_valid_q, tt_valid_d;
    logic [NUM_COMBOS-1:0]   tt_q, tt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            stim_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tt_valid_q <= 1'b0;
            tt_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            stim_q     <= stim_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tt_valid_q <= tt_valid_d;
            tt_q       <= tt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        stim_d     = stim_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tt_valid_d = tt_valid_q;
        tt_d       = tt_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SETTLE;
                    idx_d      = '0;
                    cnt_d      = '0;
                    stim_d     = '0;
                    busy_d     = 1'b1;
                    tt_valid_d = 1'b0;
                    tt_d       = '0;
                end
            end
            SETTLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // X on the gate output is captured unchanged so a broken netlist stays visible.
                tt_d[idx_q[N_INPUTS-1:0]] = dut_out;
                if (idx_q == LAST_IDX) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    tt_valid_d = 1'b1;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    stim_d  = idx_d[N_INPUTS-1:0];
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        // Abort cancels a run but keeps whatever part of the table was already captured.
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b0;
            tt_valid_d = 1'b0;
            stim_d     = '0;
            tt_d       = tt_q;
        end
    end

    always_comb begin
        stim        = stim_q;
        busy        = busy_q;
        done        = done_q;
        tt_valid    = tt_valid_q;
        truth_table = tt_q;
    end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
- Sequential harness that wraps one combinational N-input logic gate module, e.g. a 3-input truth-table gate.
- Upstream role: drives every input combination onto the gate inputs in ascending order.
- Downstream role: samples the gate output after a programmable settle time and assembles the 2^N-bit truth table.
- Used to check synthesized gate netlists against their intended truth-table value.

Parameters:
- N_INPUTS, 3, number of gate inputs (1..6).
- SETTLE_CYCLES, 2, cycles each combination is held before sampling (>=1).
- NUM_COMBOS, 2**N_INPUTS, derived localparam; not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; honoured only in IDLE.
- abort  input  1  synchronous cancel of a run in progress.
- stim  output  N_INPUTS  gate inputs; bit0=in1, bit1=in2, bit2=in3 (index = {in3,in2,in1}).
- dut_out  input  1  gate output being characterised.
- busy  output  1  high from start acceptance through the DONE cycle.
- done  output  1  single-cycle pulse when the table is complete.
- tt_valid  output  1  truth_table holds a complete result.
- truth_table  output  NUM_COMBOS  bit k = dut_out observed with stim==k.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, stim=0, busy=0, done=0, tt_valid=0, truth_table=0, idx=0, cnt=0. Reset has priority over start and abort.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → SETTLE, with idx=0, stim=0, cnt=0, busy=1, tt_valid=0, truth_table=0.
  - start=0 → remain in IDLE; outputs hold.
- SETTLE:
  - cnt increments every cycle.
  - cnt==SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (1 cycle):
  - truth_table[idx] <= dut_out.
  - idx==NUM_COMBOS-1 → DONE.
  - Otherwise idx<=idx+1, stim<=idx+1, cnt<=0, → SETTLE.
- DONE (1 cycle):
  - done=1 and tt_valid=1 are asserted on entry to DONE, i.e. as registered outputs during the DONE cycle.
  - On exit to IDLE: busy=0, done=0, tt_valid stays 1.
- Timing:
  - stim holds each value for exactly SETTLE_CYCLES+1 cycles and changes only on SAMPLE→SETTLE transitions.
  - The sampled dut_out has been driven by a stable stim for SETTLE_CYCLES full cycles.
  - Latency: done is high in the cycle that begins NUM_COMBOS*(SETTLE_CYCLES+1) edges after the start-accept edge. Defaults give 24 edges.
- Start handling:
  - start while busy, including in DONE: ignored, no effect on the run.
  - start held high continuously: a new run begins in the cycle after DONE returns to IDLE.
- abort=1 in SETTLE/SAMPLE/DONE: next state IDLE, busy=0, done=0, tt_valid=0, stim=0, truth_table retains its partial contents. abort in IDLE: no effect.
- abort and start together in IDLE: start wins (abort is a no-op in IDLE).
- Widths:
  - idx is N_INPUTS+1 bits wide so the comparison never wraps.
  - cnt is $clog2(SETTLE_CYCLES+1) bits wide.
  - stim is idx truncated to N_INPUTS bits.
- dut_out is sampled only in SAMPLE; changes at any other time are ignored. X on dut_out in SAMPLE is stored as-is.

Decomposition:
- Shared package tt_pkg holds:
  - the state enum tt_state_e {IDLE, SETTLE, SAMPLE, DONE};
  - a function num_combos(n) returning 2**n;
  - the parameter legality bounds (N_INPUTS max 6, SETTLE_CYCLES min 1).
- No sub-module. The settle counter and FSM are small enough to stay in this module; the gate under test is instantiated by the enclosing harness, not inside this block.

Test Plan:
- Gate with index{in3,in2,in1} → out of 0→0, 1→1, 2→1, 3→1, 4→0, 5→1, 6→0, 7→1; N=3, S=2; pulse start → done at edge 24, truth_table=8'hAE, tt_valid=1, busy=0 next cycle.
- Gate = constant 0, then a second run with an AND3 gate → first run gives 8'h00; the second start clears tt_valid; second run gives 8'h80.
- Same setup as the first test; pulse start again at edges 5 and 23 → both ignored; done exactly once at edge 24; stim sequence 0,0,0,1,1,1,...,7,7,7.
- Assert abort at edge 10 → IDLE next cycle, busy=0, tt_valid=0, no done pulse, stim=0; truth_table[2:0] already captured, rest 0.
- Assert rst at edge 15 together with start → all outputs at reset values, state IDLE, start not honoured.
- N=1, S=1 with an inverter gate → done at edge 4, truth_table=2'b01; stim toggles 0,0,1,1.
